sm_regdump: RTL and testbench

SM_REGDUMP -- requirements
Module: sm_regdump

---
 rtl/sm_regdump.sv | 145 ++++++++++++++
 tb/tb_sm_regdump.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_regdump.sv
// sm_regdump: serial register dump engine.
// On a start request in IDLE, reads the 32 debug registers (address 0..31,
// address 0 = PC) one word at a time through regAddr/regData, and sends each
// word MS byte first as four 8N1 UART frames (LSB first, idle high) on tx.
//
// Ports:
//   clk      - clock, all state changes on the rising edge
//   rst      - synchronous active-high reset
//   start    - dump request, honoured only in IDLE
//   regAddr  - debug read address (current word; 0 while idle)
//   regData  - debug read data, combinational in regAddr
//   tx       - serial output line
//   busy     - high while a dump is in progress (low in IDLE and FINISH)
//   done     - one-cycle pulse after the last stop bit
module sm_regdump #(
    parameter int BAUD_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] DATA   = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] FINISH = 3'd5;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    logic [2:0]  state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_cnt;
    logic [1:0]  byte_cnt;
    logic [4:0]  word_cnt;
    logic [31:0] shadow;
    logic [7:0]  cur_byte;
    logic        bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            shadow   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (start) begin
                        state    <= LOAD;
                        word_cnt <= '0;
                        byte_cnt <= '0;
                    end
                end
                LOAD: begin
                    // The only sampling point of regData for this word.
                    shadow   <= regData;
                    baud_cnt <= '0;
                    state    <= START;
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) state <= STOP;
                        else                 bit_cnt <= bit_cnt + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (byte_cnt != 2'd3) begin
                            byte_cnt <= byte_cnt + 2'd1;
                            state    <= START;
                        end else if (word_cnt != 5'd31) begin
                            word_cnt <= word_cnt + 5'd1;
                            byte_cnt <= '0;
                            state    <= LOAD;
                        end else begin
                            state <= FINISH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                FINISH: begin
                    // Counters return to 0 so the next dump starts clean.
                    word_cnt <= '0;
                    byte_cnt <= '0;
                    bit_cnt  <= '0;
                    baud_cnt <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte 0 of a word is its most significant byte.
    always_comb begin
        cur_byte = shadow[31:24];
        case (byte_cnt)
            2'd0: cur_byte = shadow[31:24];
            2'd1: cur_byte = shadow[23:16];
            2'd2: cur_byte = shadow[15:8];
            2'd3: cur_byte = shadow[7:0];
            default: cur_byte = shadow[31:24];
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = cur_byte[bit_cnt];
            default: tx = 1'b1;
        endcase
    end

    assign regAddr = (state == IDLE) ? 5'd0 : word_cnt;
    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH);

endmodule

// File: tb/tb_sm_regdump.sv
// Bench for sm_regdump: a BAUD_DIV=4 instance for the main scenarios and a
// BAUD_DIV=2 instance for the narrow-bit corner. A UART receiver model
// decodes tx into byte queues which are compared with the register model.
module tb_sm_regdump;

    localparam int B0 = 4;
    localparam int B1 = 2;
    localparam int DUMP0 = 32 * (1 + 40 * B0);   // busy-rise to done
    localparam int DUMP1 = 32 * (1 + 40 * B1);

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [4:0]  regAddr0, regAddr1;
    logic [31:0] regData0, regData1;
    logic        tx0, tx1, busy0, busy1, done0, done1;

    logic [31:0] reg_val [32];
    logic [31:0] exp_val [32];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rst_cnt = 0;
    int done_cnt0 = 0, done_cnt1 = 0;
    int ferr0 = 0, ferr1 = 0;
    logic [7:0] rx0 [$];
    logic [7:0] rx1 [$];

    always #5 clk = ~clk;

    assign regData0 = reg_val[regAddr0];
    assign regData1 = reg_val[regAddr1];

    sm_regdump #(.BAUD_DIV(B0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .regAddr(regAddr0),
        .regData(regData0), .tx(tx0), .busy(busy0), .done(done0));

    sm_regdump #(.BAUD_DIV(B1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .regAddr(regAddr1),
        .regData(regData1), .tx(tx1), .busy(busy1), .done(done1));

    always @(posedge clk) if (rst) rst_cnt++;

    always @(negedge clk) begin
        cyc++;
        if (done0) done_cnt0++;
        if (done1) done_cnt1++;
    end

    function automatic logic get_tx(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction

    // UART receiver: resync on each falling edge, sample mid-bit, drop
    // frames interrupted by reset.
    task automatic decode(input int sel, input int b);
        logic last = 1'b1;
        logic [7:0] d;
        logic v;
        int rc;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 1'b1;
                continue;
            end
            if (last && get_tx(sel) == 1'b0) begin
                rc = rst_cnt;
                d = '0;
                for (int k = 0; k < 10; k++) begin
                    repeat (k == 0 ? b / 2 : b) @(negedge clk);
                    v = get_tx(sel);
                    if (k >= 1 && k <= 8) d[k-1] = v;
                    if (k == 9 && v != 1'b1 && rc == rst_cnt) begin
                        if (sel == 0) ferr0++; else ferr1++;
                    end
                end
                if (rc == rst_cnt) begin
                    if (sel == 0) rx0.push_back(d); else rx1.push_back(d);
                end
                last = 1'b1;
            end else begin
                last = get_tx(sel);
            end
        end
    endtask

    initial decode(0, B0);
    initial decode(1, B1);

    // Runs one full dump on dut0 and checks timing, busy, frames and bytes
    // against exp_val.
    task automatic run_dump0(input string tag);
        int cb, cd, d0, nbad;
        logic busy_ok;
        d0 = done_cnt0;
        start0 = 1'b1;
        for (int i = 0; i < 20 && !busy0; i++) @(negedge clk);
        total++;
        if (!busy0) begin
            bad++;
            $display("FAIL %s_busy_rise: busy=%0b required 1", tag, busy0);
        end
        cb = cyc;
        start0 = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < DUMP0 + 100 && !done0; i++) begin
            if (!busy0) busy_ok = 1'b0;
            @(negedge clk);
        end
        cd = cyc;
        total++;
        if (!done0 || (cd - cb) != DUMP0) begin
            bad++;
            $display("FAIL %s_latency: done=%0b after %0d cycles required %0d", tag, done0, cd - cb, DUMP0);
        end
        total++;
        if (busy_ok !== 1'b1 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy: held=%0b busy_at_done=%0b required 1/0", tag, busy_ok, busy0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt0 - d0 != 1 || ferr0 != 0) begin
            bad++;
            $display("FAIL %s_done_count: dones=%0d frame_errs=%0d required 1/0", tag, done_cnt0 - d0, ferr0);
        end
        total++;
        if (rx0.size() != 128) begin
            bad++;
            $display("FAIL %s_nbytes: got %0d required 128", tag, rx0.size());
        end else begin
            nbad = 0;
            for (int w = 0; w < 32; w++)
                for (int k = 0; k < 4; k++)
                    if (rx0[w*4+k] !== exp_val[w][31-8*k -: 8]) nbad++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL %s_bytes: %0d wrong bytes, first word exp %h", tag, nbad, exp_val[0]);
            end
        end
        rx0.delete();
        ferr0 = 0;
    endtask

    task automatic set_spec_model();
        reg_val[0] = 32'h0000_0010;
        for (int a = 1; a < 32; a++) reg_val[a] = 32'hA500_0000 + 32'(a);
        for (int a = 0; a < 32; a++) exp_val[a] = reg_val[a];
    endtask

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b1; start1 = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || regAddr0 !== 5'd0) begin
            bad++;
            $display("FAIL reset_outputs: tx=%b busy=%b done=%b addr=%0d required 1/0/0/0", tx0, busy0, done0, regAddr0);
        end
        total++;
        if (tx1 !== 1'b1 || busy1 !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs_b2: tx=%b busy=%b required 1/0", tx1, busy1);
        end
        rst = 1'b0; start0 = 1'b0; start1 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || busy1 !== 1'b0 || regAddr0 !== 5'd0) begin
            bad++;
            $display("FAIL reset_start_ignored: busy=%b/%b addr=%0d required 0/0/0", busy0, busy1, regAddr0);
        end
    endtask

    task automatic test_spec_dump();
        set_spec_model();
        run_dump0("spec");
    endtask

    task automatic test_random_dump();
        for (int a = 0; a < 32; a++) begin
            reg_val[a] = $urandom;
            exp_val[a] = reg_val[a];
        end
        run_dump0("rand");
    endtask

    task automatic test_snapshot();
        logic [31:0] n5, n6;
        set_spec_model();
        n5 = $urandom; n6 = $urandom;
        exp_val[6] = n6;
        fork
            run_dump0("snap");
            begin
                for (int i = 0; i < DUMP0 && regAddr0 != 5'd5; i++) @(negedge clk);
                repeat (3) @(negedge clk);
                reg_val[5] = n5;
                reg_val[6] = n6;
            end
        join
    endtask

    task automatic test_reset_mid();
        int d0;
        set_spec_model();
        d0 = done_cnt0;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        for (int i = 0; i < DUMP0 && regAddr0 != 5'd7; i++) @(negedge clk);
        total++;
        if (regAddr0 !== 5'd7) begin
            bad++;
            $display("FAIL rmid_reach_word7: addr=%0d required 7", regAddr0);
        end
        // Into the data bits of byte 2 of word 7.
        repeat (1 + 2 * 10 * B0 + B0 + 10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (tx0 !== 1'b1 || busy0 !== 1'b0 || regAddr0 !== 5'd0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL rmid_outputs: tx=%b busy=%b addr=%0d done=%b required 1/0/0/0", tx0, busy0, regAddr0, done0);
        end
        repeat (60) @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || done_cnt0 != d0) begin
            bad++;
            $display("FAIL rmid_no_resume: busy=%b dones=%0d required 0/0", busy0, done_cnt0 - d0);
        end
        rx0.delete();
        ferr0 = 0;
        run_dump0("rmid_restart");
    endtask

    task automatic test_start_ignored();
        int d0;
        set_spec_model();
        d0 = done_cnt0;
        fork
            run_dump0("ign");
            begin
                for (int k = 0; k < 60; k++) begin
                    repeat (100) @(negedge clk);
                    if (busy0) begin
                        start0 = 1'b1;
                        @(negedge clk);
                        start0 = 1'b0;
                    end
                end
            end
        join
        total++;
        if (done_cnt0 - d0 != 1 || busy0 !== 1'b0 || rx0.size() != 0) begin
            bad++;
            $display("FAIL ign_extra: dones=%0d busy=%b extra_bytes=%0d required 1/0/0", done_cnt0 - d0, busy0, rx0.size());
        end
    endtask

    task automatic test_back_to_back();
        int cb;
        set_spec_model();
        start0 = 1'b1;
        for (int i = 0; i < 20 && !busy0; i++) @(negedge clk);
        for (int i = 0; i < DUMP0 + 100 && !done0; i++) @(negedge clk);
        total++;
        if (done0 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done: done=%b required 1", done0);
        end
        @(negedge clk);
        total++;
        if (busy0 !== 1'b0 || done0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b required 0/0", busy0, done0);
        end
        @(negedge clk);
        cb = cyc;
        total++;
        if (busy0 !== 1'b1 || regAddr0 !== 5'd0) begin
            bad++;
            $display("FAIL b2b_restart: busy=%b addr=%0d required 1/0", busy0, regAddr0);
        end
        start0 = 1'b0;
        for (int i = 0; i < DUMP0 + 100 && !done0; i++) @(negedge clk);
        total++;
        if (done0 !== 1'b1 || cyc - cb != DUMP0) begin
            bad++;
            $display("FAIL b2b_second: done=%b after %0d required 1 after %0d", done0, cyc - cb, DUMP0);
        end
        repeat (3) @(negedge clk);
        total++;
        if (rx0.size() != 256 || ferr0 != 0 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_frames: bytes=%0d ferr=%0d busy=%b required 256/0/0", rx0.size(), ferr0, busy0);
        end
        rx0.delete();
        ferr0 = 0;
    endtask

    task automatic test_baud2();
        int cb, nbad;
        logic idle_ok;
        for (int a = 0; a < 32; a++) begin
            reg_val[a] = $urandom;
            exp_val[a] = reg_val[a];
        end
        rx1.delete();
        idle_ok = 1'b1;
        repeat (5) begin
            if (tx1 !== 1'b1) idle_ok = 1'b0;
            @(negedge clk);
        end
        start1 = 1'b1;
        for (int i = 0; i < 20 && !busy1; i++) @(negedge clk);
        cb = cyc;
        start1 = 1'b0;
        for (int i = 0; i < DUMP1 + 100 && !done1; i++) @(negedge clk);
        total++;
        if (done1 !== 1'b1 || cyc - cb != DUMP1) begin
            bad++;
            $display("FAIL b2_latency: done=%b after %0d required 1 after %0d", done1, cyc - cb, DUMP1);
        end
        repeat (10) begin
            @(negedge clk);
            if (tx1 !== 1'b1) idle_ok = 1'b0;
        end
        total++;
        if (idle_ok !== 1'b1) begin
            bad++;
            $display("FAIL b2_idle_high: tx idle=%b required 1", idle_ok);
        end
        total++;
        nbad = 0;
        if (rx1.size() == 128) begin
            for (int w = 0; w < 32; w++)
                for (int k = 0; k < 4; k++)
                    if (rx1[w*4+k] !== exp_val[w][31-8*k -: 8]) nbad++;
        end
        if (rx1.size() != 128 || nbad != 0 || ferr1 != 0) begin
            bad++;
            $display("FAIL b2_bytes: n=%0d wrong=%0d ferr=%0d required 128/0/0", rx1.size(), nbad, ferr1);
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        for (int a = 0; a < 32; a++) reg_val[a] = '0;
        @(negedge clk);
        test_reset();
        test_spec_dump();
        test_random_dump();
        test_snapshot();
        test_reset_mid();
        test_start_ignored();
        test_back_to_back();
        test_baud2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
